// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: two requester channels plus the shared response channel of alu_arbiter.
interface alu_arbiter_if;
   logic        req0_valid, req0_ready, req1_valid, req1_ready;
   logic [31:0] req0_a, req0_b, req1_a, req1_b;
   logic [1:0]  req0_op, req1_op;
   logic        rsp_valid, rsp_ready, rsp_id;
   logic [31:0] rsp_result;
   modport master (
      output req0_valid, req0_a, req0_b, req0_op,
      output req1_valid, req1_a, req1_b, req1_op,
      output rsp_ready,
      input  req0_ready, req1_ready, rsp_valid, rsp_id, rsp_result
   );
   modport slave (
      input  req0_valid, req0_a, req0_b, req0_op,
      input  req1_valid, req1_a, req1_b, req1_op,
      input  rsp_ready,
      output req0_ready, req1_ready, rsp_valid, rsp_id, rsp_result
   );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: two requesters share one 32-bit ALU, one operation in flight (IDLE/EXEC/RESP).
// Define ALU_ARBITER_FIXED_PRIO_EN for fixed priority (requester 0 wins); default is round-robin.
module alu_arbiter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   alu_arbiter_if.slave     bus,
   output logic             busy,
   output logic [CNT_W-1:0] cnt0,
   output logic [CNT_W-1:0] cnt1
);
   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
   state_t      state, state_nx;
   logic        gnt, acc, done;
   logic [31:0] a_q, b_q, alu;
   logic [1:0]  op_q;
`ifndef ALU_ARBITER_FIXED_PRIO_EN
   logic        last_grant;
`endif
   always_comb begin
`ifdef ALU_ARBITER_FIXED_PRIO_EN
      gnt = ~bus.req0_valid;
`else
      gnt = (bus.req0_valid & bus.req1_valid) ? ~last_grant : bus.req1_valid;
`endif
      // ready is gated by rst_n so nothing is accepted while reset is held
      bus.req0_ready = rst_n & (state == IDLE) & bus.req0_valid & ~gnt;
      bus.req1_ready = rst_n & (state == IDLE) & bus.req1_valid & gnt;
      acc = bus.req0_ready | bus.req1_ready;
      done = (state == RESP) & bus.rsp_ready;
      state_nx = (state == IDLE && acc)  ? EXEC :
                 (state == EXEC)         ? RESP :
                 (state == RESP && done) ? IDLE : state;
      alu = op_q[1] ? (op_q[0] ? a_q >> b_q : a_q << b_q)
                    : (op_q[0] ? a_q - b_q  : a_q + b_q);
   end
   assign busy = (state != IDLE);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         a_q            <= '0;
         b_q            <= '0;
         op_q           <= '0;
         bus.rsp_valid  <= 1'b0;
         bus.rsp_id     <= 1'b0;
         bus.rsp_result <= '0;
         cnt0           <= '0;
         cnt1           <= '0;
      end else begin
         state <= state_nx;
         if (acc) begin
            a_q        <= gnt ? bus.req1_a  : bus.req0_a;
            b_q        <= gnt ? bus.req1_b  : bus.req0_b;
            op_q       <= gnt ? bus.req1_op : bus.req0_op;
            bus.rsp_id <= gnt;
         end
         if (state == EXEC) begin
            bus.rsp_result <= alu;
            bus.rsp_valid  <= 1'b1;
         end
         if (done) bus.rsp_valid <= 1'b0;
         if (done && !bus.rsp_id && !(&cnt0)) cnt0 <= cnt0 + CNT_W'(1);
         if (done && bus.rsp_id && !(&cnt1)) cnt1 <= cnt1 + CNT_W'(1);
      end
   end
`ifndef ALU_ARBITER_FIXED_PRIO_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) last_grant <= 1'b1;
      else if (acc) last_grant <= gnt;
   end
`endif
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed vectors with hand-computed results for alu_arbiter (CNT_W=2).
module tb_alu_arbiter;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       busy;
   logic [1:0] cnt0, cnt1;
   int         checks = 0;
   int         errors = 0;
   alu_arbiter_if bus();
   alu_arbiter #(.CNT_W(2)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus), .busy(busy), .cnt0(cnt0), .cnt1(cnt1)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask
   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask
   task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] b,
                        input logic [1:0] op, input logic [31:0] exp);
      @(negedge clk);
      bus.rsp_ready = 1'b1;
      if (w) begin
         bus.req1_valid = 1'b1; bus.req1_a = a; bus.req1_b = b; bus.req1_op = op;
      end else begin
         bus.req0_valid = 1'b1; bus.req0_a = a; bus.req0_b = b; bus.req0_op = op;
      end
      #1;
      chk("accept_ready", w ? bus.req1_ready : bus.req0_ready, 1);
      @(negedge clk);
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      chk("exec_valid", bus.rsp_valid, 0);
      chk("exec_busy", busy, 1);
      @(negedge clk);
      chk("rsp_valid", bus.rsp_valid, 1);
      chk("rsp_result", bus.rsp_result, exp);
      chk("rsp_id", bus.rsp_id, w);
      @(negedge clk);
      chk("done_valid", bus.rsp_valid, 0);
      chk("done_busy", busy, 0);
   endtask
   initial begin
      logic w;
      bus.req0_valid = 1'b1; bus.req0_a = '0; bus.req0_b = '0; bus.req0_op = '0;
      bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_op = '0;
      bus.rsp_ready = 1'b0;
      #2;
      chk("rst_ready0", bus.req0_ready, 0);
      chk("rst_valid", bus.rsp_valid, 0);
      chk("rst_id", bus.rsp_id, 0);
      chk("rst_result", bus.rsp_result, 0);
      chk("rst_busy", busy, 0);
      chk("rst_cnt0", cnt0, 0);
      chk("rst_cnt1", cnt1, 0);
      bus.req0_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      // single op and edge arithmetic
      issue(0, 32'd5, 32'd3, 2'b00, 32'd8);
      chk("single_cnt0", cnt0, 1);
      issue(0, 32'd0, 32'd1, 2'b01, 32'hFFFF_FFFF);
      issue(1, 32'h8000_0000, 32'd31, 2'b11, 32'd1);
      issue(0, 32'd1, 32'd32, 2'b10, 32'd0);
      issue(1, 32'hFFFF_FFFF, 32'd1, 2'b00, 32'd0);
      issue(1, 32'h0000_00F0, 32'd4, 2'b11, 32'h0F);
      chk("edge_cnt0", cnt0, 3);
      chk("edge_cnt1", cnt1, 3);
      // continuous tie
      do_reset();
      @(negedge clk);
      bus.rsp_ready = 1'b1;
      bus.req0_valid = 1'b1; bus.req0_a = 32'd10; bus.req0_b = 32'd3; bus.req0_op = 2'b01;
      bus.req1_valid = 1'b1; bus.req1_a = 32'd1;  bus.req1_b = 32'd4; bus.req1_op = 2'b10;
      #1;
      for (int k = 0; k < 4; k++) begin
`ifdef ALU_ARBITER_FIXED_PRIO_EN
         w = 1'b0;
`else
         w = k[0];
`endif
         chk("tie_ready0", bus.req0_ready, !w);
         chk("tie_ready1", bus.req1_ready, w);
         @(negedge clk);
         @(negedge clk);
         chk("tie_id", bus.rsp_id, w);
         chk("tie_result", bus.rsp_result, w ? 32'd16 : 32'd7);
         @(negedge clk);
         if (k == 3) begin
            bus.req0_valid = 1'b0;
            bus.req1_valid = 1'b0;
         end
         #1;
      end
`ifdef ALU_ARBITER_FIXED_PRIO_EN
      chk("tie_cnt0", cnt0, 3);
      chk("tie_cnt1", cnt1, 0);
`else
      chk("tie_cnt0", cnt0, 2);
      chk("tie_cnt1", cnt1, 2);
`endif
      issue(1, 32'd7, 32'd2, 2'b00, 32'd9);
      // backpressure
      do_reset();
      @(negedge clk);
      bus.rsp_ready = 1'b0;
      bus.req0_valid = 1'b1; bus.req0_a = 32'd2; bus.req0_b = 32'd2; bus.req0_op = 2'b00;
      #1;
      chk("bp_ready0", bus.req0_ready, 1);
      @(negedge clk);
      bus.req0_valid = 1'b0;
      @(negedge clk);
      bus.req0_valid = 1'b1;
      bus.req1_valid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         #1;
         chk("bp_valid", bus.rsp_valid, 1);
         chk("bp_result", bus.rsp_result, 4);
         chk("bp_id", bus.rsp_id, 0);
         chk("bp_ready0", bus.req0_ready, 0);
         chk("bp_ready1", bus.req1_ready, 0);
         chk("bp_busy", busy, 1);
         @(negedge clk);
      end
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      bus.rsp_ready = 1'b1;
      chk("bp_last_valid", bus.rsp_valid, 1);
      @(negedge clk);
      chk("bp_done_valid", bus.rsp_valid, 0);
      chk("bp_cnt0", cnt0, 1);
      // reset while in RESP
      @(negedge clk);
      bus.rsp_ready = 1'b0;
      bus.req1_valid = 1'b1; bus.req1_a = 32'd3; bus.req1_b = 32'd1; bus.req1_op = 2'b00;
      @(negedge clk);
      bus.req1_valid = 1'b0;
      @(negedge clk);
      chk("rr_pre_valid", bus.rsp_valid, 1);
      rst_n = 1'b0;
      #1;
      chk("rr_valid", bus.rsp_valid, 0);
      chk("rr_busy", busy, 0);
      chk("rr_cnt0", cnt0, 0);
      chk("rr_cnt1", cnt1, 0);
      @(negedge clk);
      rst_n = 1'b1;
      issue(0, 32'd5, 32'd3, 2'b00, 32'd8);
      chk("rr_after_cnt0", cnt0, 1);
      chk("rr_after_cnt1", cnt1, 0);
      // saturation
      for (int k = 0; k < 5; k++) begin
         issue(1, 32'd1, 32'd1, 2'b00, 32'd2);
         chk("sat_cnt1", cnt1, (k < 3) ? k + 1 : 3);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: CNT_W, default 16, width of the per-requester completed-operation counters.
REQ-002 Clocking SHALL be: one clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 req0_valid / req1_valid  input  1  requester N presents an operation.
REQ-006 req0_ready / req1_ready  output  1  arbiter accepts requester N's operation this cycle.
REQ-007 req0_a, req0_b / req1_a, req1_b  input  32  operands A and B.
REQ-008 req0_op / req1_op  input  2  opcode: 00 add, 01 sub, 10 shift-left, 11 shift-right-logical.
REQ-009 rsp_valid  output  1  result available.
REQ-010 rsp_ready  input  1  consumer takes result.
REQ-011 rsp_id  output  1  requester index that owns the result.
REQ-012 rsp_result  output  32  ALU result.
REQ-013 busy  output  1  high in any state other than IDLE.
REQ-014 cnt0 / cnt1  output  CNT_W  completed-operation count per requester.

Function
REQ-015 One shared 32-bit four-op ALU SHALL serve both requesters, one operation in flight at a time.
REQ-016 FSM states SHALL be IDLE, EXEC and RESP.
REQ-017 IDLE: reqN_ready = 1 combinationally only for the granted requester when its valid is high; otherwise 0.
REQ-018 IDLE: on an accept (valid & ready), latch A, B, op and id, then go to EXEC.
REQ-019 EXEC: register the ALU result from the latched operands into rsp_result, set rsp_valid, then go to RESP.
REQ-020 RESP: hold rsp_valid, rsp_id and rsp_result stable until rsp_ready = 1; on that handshake clear rsp_valid and return to IDLE.
REQ-021 Latency: accept at cycle T gives rsp_valid at T+2; minimum issue interval is 3 cycles.
REQ-022 reqN_ready SHALL be 0 in EXEC and RESP.
REQ-023 Arbitration: round-robin; when both are valid in IDLE, grant the requester not granted last. last_grant resets to 1, so requester 0 wins the first tie.
REQ-024 A single valid requester SHALL be granted regardless of last_grant.
REQ-025 last_grant SHALL update at accept time.
REQ-026 Arithmetic: add/sub wrap modulo 2^32; shifts use the full 32-bit B as the shift amount; B >= 32 yields 0.
REQ-027 On each rsp handshake, cnt[rsp_id] SHALL increment and saturate at 2^CNT_W-1 (no wrap).
REQ-028 A requester dropping valid before being granted SHALL be permitted; no state change results.

Reset
REQ-029 rst_n low SHALL force immediately: state = IDLE, rsp_valid = 0, rsp_id = 0, rsp_result = 0, cnt0 = cnt1 = 0, last_grant = 1, busy = 0.
REQ-030 Reset mid-operation (EXEC or RESP) SHALL discard the in-flight operation; no response is issued and no counter changes.
REQ-031 reqN_ready SHALL be 0 while rst_n is low.

Configuration
REQ-032 Macro ALU_ARBITER_FIXED_PRIO_EN: when defined, arbitration SHALL be fixed priority with requester 0 always winning ties, and last_grant is unused.
REQ-033 Without ALU_ARBITER_FIXED_PRIO_EN, the round-robin arbitration of REQ-023 SHALL apply.

Verification
REQ-034 Single op: req0 with A=5, B=3, op=00, rsp_ready=1 -> rsp_valid at T+2, rsp_result=8, rsp_id=0, cnt0=1.
REQ-035 Tie, round-robin: both valid continuously, req0 sub 10-3 and req1 shl 1<<4 -> grants 0,1,0,1; results 7 and 16 alternate with matching rsp_id. With FIXED_PRIO_EN defined, only id 0 is served.
REQ-036 Backpressure: rsp_ready=0 for 5 cycles after rsp_valid -> rsp fields stable, both readys 0, busy=1; completion on the first cycle rsp_ready=1.
REQ-037 Edge arithmetic: sub 0-1 -> 0xFFFFFFFF; shr 0x80000000 by 31 -> 1; shl by B=32 -> 0; add 0xFFFFFFFF+1 -> 0.
REQ-038 Reset in RESP: assert rst_n low while rsp_valid=1 -> rsp_valid=0 without a clock edge; counters 0; next accept proceeds normally.
REQ-039 Saturation: CNT_W=2, 5 req1 ops -> cnt1 sticks at 3.
